// File: rtl/tick_meter_pkg.sv
// Shared types and helpers for the tick frequency meter.
// Holds the FSM state encoding and the gate-counter width helper.
package tick_meter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        GATE = 1'b1
    } meter_state_e;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int gate_w(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/tick_freq_meter_rise_detect.sv
// Rising-edge detector for a clk_in-synchronous level.
// The previous value is registered every cycle regardless of FSM state.
import tick_meter_pkg::*;

module rise_detect (
    input  logic clk_in,
    input  logic rst,
    input  logic sig_in,
    output logic rise
);

    logic prev_q;

    // Remember last cycle's level so a held-high input counts once.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= sig_in;
        end
    end

    assign rise = sig_in & ~prev_q;

endmodule

// File: rtl/tick_freq_meter.sv
// Tick-rate meter: counts rising edges of tick_in over a fixed
// GATE_CYCLES window and hands each result over a valid/ack port.
import tick_meter_pkg::*;

module tick_freq_meter #(
    parameter int GATE_CYCLES = 50,
    parameter int CNT_W       = 8
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             enable,
    input  logic             tick_in,
    output logic [CNT_W-1:0] freq_out,
    output logic             freq_valid,
    input  logic             freq_ack,
    output logic             overflow,
    output logic             overrun
);

    localparam int             GW        = gate_w(GATE_CYCLES);
    localparam logic [GW-1:0]  GATE_LOAD = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    meter_state_e     state_q, state_d;
    logic [GW-1:0]    gate_q, gate_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_n;
    logic             sat_q, sat_d, sat_n;
    logic [CNT_W-1:0] freq_q, freq_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic             ovr_q, ovr_d;
    logic             rise;

    rise_detect u_rise (
        .clk_in (clk_in),
        .rst    (rst),
        .sig_in (tick_in),
        .rise   (rise)
    );

    // Candidate count for this cycle, saturating at the top value.
    always_comb begin
        cnt_n = cnt_q;
        sat_n = sat_q;
        if (rise) begin
            if (cnt_q == CNT_MAX) begin
                sat_n = 1'b1;
            end else begin
                cnt_n = cnt_q + CNT_W'(1);
            end
        end
    end

    // Next-state, window bookkeeping and result handover.
    always_comb begin
        state_d = state_q;
        gate_d  = gate_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        freq_d  = freq_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        ovr_d   = ovr_q;

        if (freq_ack && valid_q) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                gate_d = '0;
                cnt_d  = '0;
                sat_d  = 1'b0;
                if (enable) begin
                    state_d = GATE;
                    gate_d  = GATE_LOAD;
                end
            end
            GATE: begin
                if (!enable) begin
                    state_d = IDLE;
                    gate_d  = '0;
                    cnt_d   = '0;
                    sat_d   = 1'b0;
                end else if (gate_q == '0) begin
                    freq_d  = cnt_n;
                    ovf_d   = sat_n;
                    valid_d = 1'b1;
                    if (valid_q && !freq_ack) begin
                        ovr_d = 1'b1;
                    end
                    gate_d = GATE_LOAD;
                    cnt_d  = '0;
                    sat_d  = 1'b0;
                end else begin
                    gate_d = gate_q - GW'(1);
                    cnt_d  = cnt_n;
                    sat_d  = sat_n;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial window.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q <= IDLE;
            gate_q  <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            freq_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gate_q  <= gate_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            freq_q  <= freq_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            ovr_q   <= ovr_d;
        end
    end

    assign freq_out   = freq_q;
    assign freq_valid = valid_q;
    assign overflow   = ovf_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_tick_freq_meter.sv
// Directed bench for tick_freq_meter: 8-bit and 4-bit result widths
// driven by the same stimulus, checked against hand-computed counts.
module tb_tick_freq_meter;

    localparam int GC = 50;

    logic       clk_in = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       tick_in = 1'b0;
    logic       freq_ack = 1'b0;

    logic [7:0] f8;
    logic       v8, of8, or8;
    logic [3:0] f4;
    logic       v4, of4, or4;

    int checks = 0;
    int errors = 0;

    tick_freq_meter #(.GATE_CYCLES(GC), .CNT_W(8)) dut8 (
        .clk_in     (clk_in),
        .rst        (rst),
        .enable     (enable),
        .tick_in    (tick_in),
        .freq_out   (f8),
        .freq_valid (v8),
        .freq_ack   (freq_ack),
        .overflow   (of8),
        .overrun    (or8)
    );

    tick_freq_meter #(.GATE_CYCLES(GC), .CNT_W(4)) dut4 (
        .clk_in     (clk_in),
        .rst        (rst),
        .enable     (enable),
        .tick_in    (tick_in),
        .freq_out   (f4),
        .freq_valid (v4),
        .freq_ack   (freq_ack),
        .overflow   (of4),
        .overrun    (or4)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    function automatic logic [GC-1:0] every(input int n, input int off);
        logic [GC-1:0] m;
        m = '0;
        for (int k = 0; k < GC; k++) begin
            if (k % n == off) m[k] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [GC-1:0] bits3(input int a, input int b,
                                             input int c);
        logic [GC-1:0] m;
        m = '0;
        m[a] = 1'b1;
        m[b] = 1'b1;
        m[c] = 1'b1;
        return m;
    endfunction

    // One full window starting in window cycle 0; ends just after the
    // edge that loads the result.
    task automatic window(input logic [GC-1:0] m, input logic ack0,
                          input logic ackl);
        for (int k = 0; k < GC; k++) begin
            tick_in  = m[k];
            freq_ack = (k == 0 && ack0) || (k == GC - 1 && ackl);
            step();
        end
        freq_ack = 1'b0;
    endtask

    logic [GC-1:0] m;

    initial begin
        // reset state
        step();
        step();
        rst = 1'b0;
        chk("rst_freq", f8, 0);
        chk("rst_valid", v8, 0);
        chk("rst_ovf", of8, 0);
        chk("rst_ovr", or8, 0);

        // 1: tick every 5 cycles from window cycle 0
        enable = 1'b1;
        step();
        window(every(5, 0), 1'b0, 1'b0);
        chk("t1_freq", f8, 10);
        chk("t1_valid", v8, 1);
        chk("t1_ovf", of8, 0);
        chk("t1_ovr", or8, 0);

        // 2: tick held high across entry and three windows
        enable   = 1'b0;
        tick_in  = 1'b1;
        freq_ack = 1'b1;
        step();
        freq_ack = 1'b0;
        step();
        chk("t2_idle_valid", v8, 0);
        enable = 1'b1;
        step();
        window('1, 1'b0, 1'b0);
        chk("t2_w1", f8, 0);
        window('1, 1'b1, 1'b0);
        chk("t2_w2", f8, 0);
        window('1, 1'b1, 1'b0);
        chk("t2_w3", f8, 0);
        chk("t2_ovr", or8, 0);
        m = '1;
        for (int k = 20; k < 30; k++) m[k] = 1'b0;
        window(m, 1'b1, 1'b0);
        chk("t2_one_rise", f8, 1);

        // 3: saturation on the narrow instance, then recovery
        window(every(2, 1), 1'b1, 1'b0);
        chk("t3_f4", f4, 15);
        chk("t3_of4", of4, 1);
        chk("t3_f8", f8, 25);
        chk("t3_of8", of8, 0);
        window(bits3(10, 20, 30), 1'b1, 1'b0);
        chk("t3_f4_next", f4, 3);
        chk("t3_of4_next", of4, 0);

        // 4: unacked result overwritten
        window(every(10, 0), 1'b1, 1'b0);
        chk("t4_first", f8, 5);
        chk("t4_first_ovr", or8, 0);
        window(every(25, 0), 1'b0, 1'b0);
        chk("t4_second", f8, 2);
        chk("t4_valid", v8, 1);
        chk("t4_ovr", or8, 1);
        tick_in  = 1'b0;
        freq_ack = 1'b1;
        step();
        freq_ack = 1'b0;
        chk("t4_ack_valid", v8, 0);
        chk("t4_ovr_sticky", or8, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t4_rst_ovr", or8, 0);
        chk("t4_rst_freq", f8, 0);
        chk("t4_rst_valid", v8, 0);

        // 5: ack on the cycle the next result loads
        step();
        window(every(5, 0), 1'b0, 1'b0);
        chk("t5_first", f8, 10);
        window(every(7, 3), 1'b0, 1'b1);
        chk("t5_freq", f8, 7);
        chk("t5_valid", v8, 1);
        chk("t5_ovr", or8, 0);

        // 6: edge on last window cycle, abort by enable, abort by rst
        m = '0;
        m[10] = 1'b1;
        m[GC-1] = 1'b1;
        window(m, 1'b1, 1'b0);
        chk("t6_last_edge", f8, 2);
        chk("t6_last_valid", v8, 1);
        m = every(5, 0);
        for (int k = 0; k < 20; k++) begin
            tick_in  = m[k];
            freq_ack = (k == 0);
            step();
        end
        freq_ack = 1'b0;
        enable   = 1'b0;
        tick_in  = 1'b0;
        step();
        for (int k = 0; k < 60; k++) begin
            tick_in = k[0];
            step();
        end
        chk("t6_dis_valid", v8, 0);
        chk("t6_dis_freq", f8, 2);
        chk("t6_dis_ovr", or8, 0);
        tick_in = 1'b0;
        enable  = 1'b1;
        step();
        window(bits3(0, 25, GC - 1), 1'b0, 1'b0);
        chk("t6_reen_freq", f8, 3);
        chk("t6_reen_valid", v8, 1);
        m = every(5, 0);
        for (int k = 0; k < 20; k++) begin
            tick_in  = m[k];
            freq_ack = (k == 0);
            step();
        end
        freq_ack = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_rst_freq", f8, 0);
        chk("t6_rst_valid", v8, 0);
        chk("t6_rst_ovf", of8, 0);
        step();
        window(every(5, 0), 1'b0, 1'b0);
        chk("t6_after_rst", f8, 10);
        chk("t6_after_valid", v8, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tick_freq_meter.md
Name: tick_freq_meter

Overview:
Measures the rate of a single-cycle tick stream, such as a divided-clock pulse output, by counting its rising edges over a fixed gate window of GATE_CYCLES clk_in cycles. With GATE_CYCLES = input clock frequency, the result is the tick frequency in Hz. It sits on the consumer side of the chronometer tick generators and gives self-check and calibration of the divider chain. Results go to a downstream reader over a valid/ack handshake.

Parameters:
GATE_CYCLES, 50, gate window length in clk_in cycles (>= 2)
CNT_W, 8, width of the measured-count result

Ports:
clk_in  input  1  system clock; all logic on its rising edge
rst  input  1  synchronous, active-high reset
enable  input  1  high = measure continuously; low = abort and idle
tick_in  input  1  tick stream, synchronous to clk_in; rising edges are counted
freq_out  output  CNT_W  count from the last completed window
freq_valid  output  1  freq_out holds an unacknowledged result
freq_ack  input  1  reader consumes the result; effective only while freq_valid=1
overflow  output  1  last completed window saturated (count > 2^CNT_W-1)
overrun  output  1  sticky: a result was overwritten before it was acked

Behaviour:
- Reset (rst=1 at a clk_in edge) clears everything:
  - freq_out=0, freq_valid=0, overflow=0, overrun=0.
  - Gate counter=0, edge counter=0, tick_prev=0, state=IDLE.
  - Reset overrides every other input in that cycle. Reset mid-window discards the partial count.
- Edge detect: edge = tick_in & ~tick_prev. tick_prev is registered every cycle in all states.
  - A tick held high for N cycles counts once.
  - A tick already high on window entry does not count.
- State IDLE:
  - Counters are held at 0.
  - If enable=1: go to GATE. The gate counter loads GATE_CYCLES-1. The first window cycle is the next cycle.
- State GATE (one window = exactly GATE_CYCLES cycles):
  - Each cycle: if edge, the edge counter increments, saturating at 2^CNT_W-1. The internal sat flag is set on an attempted increment past the maximum.
  - Gate counter decrements each cycle. The cycle in which it equals 0 is the last window cycle. An edge in that cycle is counted in this window.
  - At the end of the last cycle:
    - freq_out <= final count (including that cycle's edge).
    - overflow <= sat. freq_valid <= 1.
    - If freq_valid=1 and freq_ack=0 at that moment, overrun <= 1.
    - Counters restart: gate = GATE_CYCLES-1, edge count 0, sat 0.
    - The next window starts on the next cycle with no gap. Stay in GATE.
  - enable=0 in any GATE cycle: go to IDLE, discard the partial count. freq_out, freq_valid, overflow and overrun keep their values.
- Handshake:
  - freq_ack while freq_valid=1 clears freq_valid on the next edge.
  - freq_ack while freq_valid=0 is ignored.
  - Ack and new result in the same cycle: the new result loads, freq_valid stays 1, overrun is not set.
- overrun clears only on rst.
- Latency: the result is visible 1 cycle after the last window cycle.
- Counter width: ceil(log2(GATE_CYCLES)) bits, minimum 1.

Decomposition:
- Package tick_meter_pkg:
  - state enum {IDLE, GATE}
  - GATE_W width function (clog2 helper)
- Sub-module rise_detect: registered previous value plus edge output, with synchronous reset.
- The counter/FSM body stays in tick_freq_meter.

Test Plan:
1. rst, enable=1, a 1-cycle tick every 5 cycles starting at window cycle 0, GATE_CYCLES=50 -> freq_out=10, freq_valid=1, overflow=0, 50 cycles after GATE entry plus 1.
2. tick_in held high from before enable through 3 windows -> freq_out=0 each window. Then one 0→1 transition mid-window -> freq_out=1.
3. CNT_W=4, tick toggling every cycle (25 edges in a 50-cycle window) -> freq_out=15, overflow=1. Next window with 3 edges -> freq_out=3, overflow=0.
4. Never assert freq_ack over two windows -> second result replaces the first, overrun=1, freq_valid stays 1. Ack once -> freq_valid=0, overrun stays 1 until rst.
5. Pulse freq_ack exactly on the cycle the second result loads -> freq_valid=1, overrun=0, freq_out=new value.
6. Edge on the last window cycle counts in the current window. Then drop enable at window cycle 20, or assert rst at cycle 20 -> IDLE, no new result, registers hold (enable) or clear to 0 (rst). Re-enable -> full 50-cycle window.
